// File: rtl/cipu_sched_pkg.sv
// cipu_sched_pkg: shared state/source encodings and characters for the
// phase scheduler and its character engines.
package cipu_sched_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F1_ST  = 4'd1,
    F1_RUN = 4'd2,
    LF_ST  = 4'd3,
    LF_RUN = 4'd4,
    F2_ST  = 4'd5,
    F2_RUN = 4'd6,
    FIN    = 4'd7,
    ERR    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_F1   = 2'd1,
    SRC_LF   = 2'd2,
    SRC_F2   = 2'd3
  } src_e;

  localparam logic [7:0] EOT_CHAR = 8'd36;
  localparam logic [7:0] SEP_CHAR = 8'd59;

  // First unmasked start state at phase index >= from, else FIN.
  function automatic state_e first_st(
    input logic [2:0] m,
    input logic [1:0] from
  );
    if (from == 2'd0 && !m[0]) return F1_ST;
    if (from <= 2'd1 && !m[1]) return LF_ST;
    if (!m[2]) return F2_ST;
    return FIN;
  endfunction

endpackage

// File: rtl/cipu_phase_sched_if.sv
// cipu_phase_sched_if: one engine channel (start pulse, character
// stream, done) between the scheduler (master) and an engine (slave).
interface cipu_phase_sched_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              done;

  modport master (output start, input valid, data, done);
  modport slave  (input start, output valid, data, done);
endinterface

// File: rtl/cipu_watchdog.sv
// cipu_watchdog: idle-cycle counter; timeout rises on the TIMEOUT-th
// consecutive enabled cycle without a clear.
module cipu_watchdog #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign timeout = en && !clr &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/cipu_phase_sched.sv
// cipu_phase_sched: runs FIFO1, LIFO, FIFO2 engines in order and muxes
// their characters out. Optional macro CIPU_SCHED_SKIP_EN adds skip_mask.
module cipu_phase_sched
  import cipu_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CIPU_SCHED_SKIP_EN
  input  logic [2:0]        skip_mask,
`endif
  input  logic              start,
  output logic              busy,
  cipu_phase_sched_if.master f1,
  cipu_phase_sched_if.master lf,
  cipu_phase_sched_if.master f2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic [2:0]        phase,
  output logic [CNT_W-1:0]  cnt_f1,
  output logic [CNT_W-1:0]  cnt_lf,
  output logic [CNT_W-1:0]  cnt_f2,
  output logic              job_done,
  output logic              err_timeout
);
  state_e            state_q, state_d, nxt;
  logic [2:0]        mask_now, mask_job;
  logic              job_go, run, own_v, own_done, wd_to;
  logic [DATA_W-1:0] own_d;
  src_e              own_src;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;
  logic [CNT_W-1:0]  cnt_f1_q, cnt_f1_d;
  logic [CNT_W-1:0]  cnt_lf_q, cnt_lf_d;
  logic [CNT_W-1:0]  cnt_f2_q, cnt_f2_d;
  logic              err_q, err_d;

  assign job_go = (state_q == IDLE) && start;

`ifdef CIPU_SCHED_SKIP_EN
  logic [2:0] skip_q, skip_d;
  assign skip_d = job_go ? skip_mask : skip_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) skip_q <= '0;
    else      skip_q <= skip_d;
  end
  assign mask_now = skip_mask;
  assign mask_job = skip_q;
`else
  assign mask_now = 3'b000;
  assign mask_job = 3'b000;
`endif

  always_comb begin
    run      = 1'b0;
    own_v    = 1'b0;
    own_done = 1'b0;
    own_d    = f1.data;
    own_src  = SRC_NONE;
    unique case (1'b1)
      state_q == F1_RUN: begin
        run = 1'b1; own_v = f1.valid; own_done = f1.done;
        own_d = f1.data; own_src = SRC_F1;
      end
      state_q == LF_RUN: begin
        run = 1'b1; own_v = lf.valid; own_done = lf.done;
        own_d = lf.data; own_src = SRC_LF;
      end
      state_q == F2_RUN: begin
        run = 1'b1; own_v = f2.valid; own_done = f2.done;
        own_d = f2.data; own_src = SRC_F2;
      end
      default: ;
    endcase
  end

  cipu_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (!run || own_v),
    .en      (run),
    .timeout (wd_to)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ERR is transient: it only marks the error and collapses to IDLE.
  always_comb begin
    nxt = state_q;
    unique case (state_q)
      IDLE:   if (start) nxt = first_st(mask_now, 2'd0);
      F1_ST:  nxt = F1_RUN;
      F1_RUN: if (own_done) nxt = first_st(mask_job, 2'd1);
              else if (wd_to) nxt = ERR;
      LF_ST:  nxt = LF_RUN;
      LF_RUN: if (own_done) nxt = first_st(mask_job, 2'd2);
              else if (wd_to) nxt = ERR;
      F2_ST:  nxt = F2_RUN;
      F2_RUN: if (own_done) nxt = FIN;
              else if (wd_to) nxt = ERR;
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    state_d = (nxt == ERR) ? IDLE : nxt;
  end

  always_comb begin
    busy     = state_q != IDLE;
    f1.start = state_q == F1_ST;
    lf.start = state_q == LF_ST;
    f2.start = state_q == F2_ST;
    job_done = state_q == FIN;
    phase    = state_q[2:0];
  end

  always_comb begin
    out_valid_d = own_v;
    out_data_d  = own_v ? own_d : out_data_q;
    out_src_d   = own_v ? own_src : SRC_NONE;
    cnt_f1_d    = cnt_f1_q;
    cnt_lf_d    = cnt_lf_q;
    cnt_f2_d    = cnt_f2_q;
    err_d       = (nxt == ERR) ? 1'b1 : err_q;
    if (job_go) begin
      cnt_f1_d = '0;
      cnt_lf_d = '0;
      cnt_f2_d = '0;
      err_d    = 1'b0;
    end else if (own_v) begin
      if (own_src == SRC_F1 && !(&cnt_f1_q))
        cnt_f1_d = cnt_f1_q + CNT_W'(1);
      if (own_src == SRC_LF && !(&cnt_lf_q))
        cnt_lf_d = cnt_lf_q + CNT_W'(1);
      if (own_src == SRC_F2 && !(&cnt_f2_q))
        cnt_f2_d = cnt_f2_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cnt_f1_q    <= '0;
      cnt_lf_q    <= '0;
      cnt_f2_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cnt_f1_q    <= cnt_f1_d;
      cnt_lf_q    <= cnt_lf_d;
      cnt_f2_q    <= cnt_f2_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign cnt_f1      = cnt_f1_q;
  assign cnt_lf      = cnt_lf_q;
  assign cnt_f2      = cnt_f2_q;
  assign err_timeout = err_q;
endmodule
